conv_17_19_sdiv_dfe: RTL and testbench

CONV_17_19_SDIV_DFE -- requirements
Module: conv_17_19_sdiv_dfe

---
 rtl/conv_17_19_sdiv_dfe_if.sv | 25 ++
 rtl/conv_17_19_sdiv_dfe.sv | 156 +++++++++++++++
 tb/tb_conv_17_19_sdiv_dfe.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_17_19_sdiv_dfe_if.sv
// Operand/result handshake bundle for the 24/8 signed divider.
// The producer side (master) offers operands and accepts results;
// the divider (slave) consumes operands and presents results.
interface conv_17_19_sdiv_dfe_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [23:0] din0;
  logic signed [7:0]  din1;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] dout;
  logic signed [7:0]  rem;
  logic               ovf;
  logic               dz;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, rem, ovf, dz
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, rem, ovf, dz
  );
endinterface

// File: rtl/conv_17_19_sdiv_dfe.sv
// Multi-cycle signed divider: 24-bit dividend / 8-bit divisor.
// Magnitudes are divided with a restoring radix-2 loop, signs are applied
// afterwards, and the quotient is saturated to 16 bits. A zero divisor
// yields a full-scale quotient of the dividend's sign with dz set.
// Latency from accept to out_valid is a fixed 26 cycles.
module conv_17_19_sdiv_dfe #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 24,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 16
) (
  input logic                    ap_clk,
  input logic                    ap_rst_n,
  conv_17_19_sdiv_dfe_if.slave   bus
);

  // Only the 24/8/16 configuration is implemented; anything else must not build.
  if (din0_WIDTH != 24 || din1_WIDTH != 8 || dout_WIDTH != 16 || ID < 0) begin : g_bad_cfg
    $error("conv_17_19_sdiv_dfe supports only din0=24, din1=8, dout=16");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // The counter reaches this value after the last radix-2 step; the cycle
  // that observes it hands off to FIX, giving the fixed 26-cycle latency.
  localparam logic [4:0] LAST_STEP = 5'(din0_WIDTH);

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [23:0] quo_q;       // dividend magnitude shifts out, quotient bits shift in
  logic [7:0]  prem_q;      // partial remainder magnitude
  logic [7:0]  dvs_q;       // divisor magnitude (128 for -128)
  logic        sign_dvd_q;
  logic        sign_dvs_q;
  logic [4:0]  cnt_q;
  logic [15:0] dout_q;
  logic [7:0]  rem_q;
  logic        ovf_q;
  logic        dz_q;

  logic [23:0] dvd_mag;
  logic [7:0]  dvs_mag;
  logic [8:0]  prem_shift;
  logic        sub_ok;
  logic [7:0]  prem_next;
  logic        q_neg;
  logic [15:0] fix_dout;
  logic [7:0]  fix_rem;
  logic        fix_ovf;
  logic        fix_dz;

  // Operand magnitudes; the two's-complement negate of the most negative
  // value is exactly its unsigned magnitude, so no extra bit is needed.
  assign dvd_mag = bus.din0[23] ? (~bus.din0 + 24'd1) : bus.din0;
  assign dvs_mag = bus.din1[7]  ? (~bus.din1 + 8'd1)  : bus.din1;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder stays below the divisor (<=128), so 8 bits hold the result.
  assign prem_shift = {prem_q, quo_q[23]};
  assign sub_ok     = prem_shift >= {1'b0, dvs_q};
  assign prem_next  = sub_ok ? 8'(prem_shift - {1'b0, dvs_q}) : prem_shift[7:0];

  // Sign application and saturation of the unsigned loop results.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    q_neg    = sign_dvd_q ^ sign_dvs_q;
    fix_dout = q_neg ? -quo_q[15:0] : quo_q[15:0];
    fix_rem  = sign_dvd_q ? -prem_q : prem_q;
    fix_ovf  = 1'b0;
    fix_dz   = 1'b0;
    if (dvs_q == 8'd0) begin
      fix_dz   = 1'b1;
      fix_dout = sign_dvd_q ? 16'h8000 : 16'h7FFF;
      fix_rem  = 8'd0;
    end else if (q_neg && (quo_q > 24'd32768)) begin
      fix_ovf  = 1'b1;
      fix_dout = 16'h8000;
    end else if (!q_neg && (quo_q > 24'd32767)) begin
      fix_ovf  = 1'b1;
      fix_dout = 16'h7FFF;
    end
  end

  // Control FSM with registered handshake outputs and the iterative datapath.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      // NOTE: the datapath registers are reset along with control so a
      // discarded operation leaves nothing behind; they are few and cheap.
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      prem_q      <= '0;
      dvs_q       <= '0;
      sign_dvd_q  <= 1'b0;
      sign_dvs_q  <= 1'b0;
      cnt_q       <= '0;
      dout_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            quo_q      <= dvd_mag;
            dvs_q      <= dvs_mag;
            sign_dvd_q <= bus.din0[23];
            sign_dvs_q <= bus.din1[7];
            prem_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          if (cnt_q == LAST_STEP) begin
            state_q <= FIX;
          end else begin
            quo_q  <= {quo_q[22:0], sub_ok};
            prem_q <= prem_next;
            cnt_q  <= cnt_q + 5'd1;
          end
        end
        FIX: begin
          dout_q      <= fix_dout;
          rem_q       <= fix_rem;
          ovf_q       <= fix_ovf;
          dz_q        <= fix_dz;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.rem       = rem_q;
  assign bus.ovf       = ovf_q;
  assign bus.dz        = dz_q;

endmodule

// File: tb/tb_conv_17_19_sdiv_dfe.sv
// Directed bench for conv_17_19_sdiv_dfe: reset, arithmetic vectors,
// back-pressure in DONE and reset in the middle of a division.
module tb_conv_17_19_sdiv_dfe;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  conv_17_19_sdiv_dfe_if bus ();

  conv_17_19_sdiv_dfe #(
    .ID(1), .din0_WIDTH(24), .din1_WIDTH(8), .dout_WIDTH(16)
  ) dut (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit o;
    bit z;
  } vec_t;

  // Drive one operation, measure edges from accept to out_valid, sample the result.
  // With hold set the result is left pending in DONE.
  task automatic run_op(input int a, input int b, input bit hold, output int lat,
                        output logic signed [15:0] q, output logic signed [7:0] r,
                        output logic o, output logic z);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.din0     = 24'(a);
    bus.din1     = 8'(b);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.din0     = ~24'(a);
    bus.din1     = ~8'(b);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    q = bus.dout;
    r = bus.rem;
    o = bus.ovf;
    z = bus.dz;
    if (!hold) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.dout !== 16'd0 || bus.rem !== 8'd0 ||
        bus.ovf !== 1'b0 || bus.dz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b dout=%0d rem=%0d ovf=%b dz=%b expected all 0",
               bus.out_valid, bus.dout, bus.rem, bus.ovf, bus.dz);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic signed [15:0] q;
    logic signed [7:0]  r;
    logic o, z;
    run_op(1000, 7, 1'b0, lat, q, r, o, z);
    n_checks++;
    if (lat !== 26) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected 26", lat);
    end
    n_checks++;
    if (q !== 16'sd142 || r !== 8'sd6 || o !== 1'b0 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got dout=%0d rem=%0d ovf=%b dz=%b expected 142/6/0/0", q, r, o, z);
    end
  endtask

  task automatic test_arith();
    vec_t vecs[10];
    int lat;
    logic signed [15:0] q;
    logic signed [7:0]  r;
    logic o, z;
    vecs = '{
      '{a: -1000,    b:  7,    q: -142,   r: -6,  o: 0, z: 0},
      '{a:  1000,    b: -7,    q: -142,   r:  6,  o: 0, z: 0},
      '{a: -8388608, b: -1,    q:  32767, r:  0,  o: 1, z: 0},
      '{a:  100000,  b:  3,    q:  32767, r:  1,  o: 1, z: 0},
      '{a:  500,     b:  0,    q:  32767, r:  0,  o: 0, z: 1},
      '{a: -5,       b:  0,    q: -32768, r:  0,  o: 0, z: 1},
      '{a: -65536,   b:  2,    q: -32768, r:  0,  o: 0, z: 0},
      '{a:  65536,   b:  2,    q:  32767, r:  0,  o: 1, z: 0},
      '{a:  1000,    b: -128,  q: -7,     r:  104, o: 0, z: 0},
      '{a: -7,       b:  7,    q: -1,     r:  0,  o: 0, z: 0}
    };
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, lat, q, r, o, z);
      n_checks++;
      if (lat !== 26) begin
        n_fail++;
        $display("FAIL arith[%0d]_latency: got %0d expected 26", i, lat);
      end
      n_checks++;
      if (q !== 16'(vecs[i].q) || r !== 8'(vecs[i].r) || o !== vecs[i].o || z !== vecs[i].z) begin
        n_fail++;
        $display("FAIL arith[%0d] %0d/%0d: got dout=%0d rem=%0d ovf=%b dz=%b expected %0d/%0d/%b/%b",
                 i, vecs[i].a, vecs[i].b, q, r, o, z, vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].z);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic signed [15:0] q;
    logic signed [7:0]  r;
    logic o, z;
    run_op(100, 7, 1'b1, lat, q, r, o, z);
    n_checks++;
    if (q !== 16'sd14 || r !== 8'sd2) begin
      n_fail++;
      $display("FAIL bp_result: got dout=%0d rem=%0d expected 14/2", q, r);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.din0     = 24'(3000 + i);
      bus.din1     = 8'(i + 1);
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.dout !== 16'sd14 || bus.rem !== 8'sd2 ||
          bus.ovf !== 1'b0 || bus.dz !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b dout=%0d rem=%0d ovf=%b dz=%b in_ready=%b expected 1/14/2/0/0/0",
                 i, bus.out_valid, bus.dout, bus.rem, bus.ovf, bus.dz, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.dout !== 16'sd14) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b in_ready=%b dout=%0d expected 0/1/14",
               bus.out_valid, bus.in_ready, bus.dout);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_queue: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    logic signed [15:0] q;
    logic signed [7:0]  r;
    logic o, z;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.din0     = 24'sd5000;
    bus.din1     = 8'sd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.dout !== 16'd0 || bus.rem !== 8'd0 ||
        bus.ovf !== 1'b0 || bus.dz !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got valid=%b dout=%0d rem=%0d ovf=%b dz=%b in_ready=%b expected all 0",
               bus.out_valid, bus.dout, bus.rem, bus.ovf, bus.dz, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b expected 1", bus.in_ready);
    end
    run_op(1000, 7, 1'b0, lat, q, r, o, z);
    n_checks++;
    if (lat !== 26 || q !== 16'sd142 || r !== 8'sd6 || o !== 1'b0 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_rerun: got lat=%0d dout=%0d rem=%0d ovf=%b dz=%b expected 26/142/6/0/0",
               lat, q, r, o, z);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.din0      = '0;
    bus.din1      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_arith();
    test_backpressure();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
